// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM
// encoding and grant-vector codes used by the top and the round-robin picker.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  // Maps a one-hot grant vector onto the ownership state it selects.
  function automatic arb_state_e grant_to_state(input logic [1:0] gnt);
    arb_state_e st;
    case (gnt)
      GNT_0:   st = OWN0;
      GNT_1:   st = OWN1;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the requester that did not own the memory last.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic       req_0,
  input  logic       req_1,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // Resolve the grant from the request pair and the previous owner
  always_comb begin
    grant = GNT_NONE;
    if (req_0 && req_1) begin
      grant = last_owner ? GNT_0 : GNT_1;
    end else if (req_0) begin
      grant = GNT_0;
    end else if (req_1) begin
      grant = GNT_1;
    end else begin
      grant = GNT_NONE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data-memory port.
// Optional atomic ownership hold via lock_x is enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              lock_0,
  input  logic              lock_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [DATA_W-1:0] rdata_0_q, rdata_0_d;
  logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
  logic              rvalid_0_q, rvalid_0_d;
  logic              rvalid_1_q, rvalid_1_d;

  logic              acc_0_s;
  logic              acc_1_s;
  logic              hold_0_s;
  logic              hold_1_s;
  logic [1:0]        grant_s;

  assign acc_0_s = (state_q == OWN0) && req_0;
  assign acc_1_s = (state_q == OWN1) && req_1;

`ifdef DMEM_ARB_LOCK_EN
  assign hold_0_s = acc_0_s && lock_0;
  assign hold_1_s = acc_1_s && lock_1;
`else
  logic unused_lock_s;
  assign unused_lock_s = lock_0 | lock_1;
  assign hold_0_s      = 1'b0;
  assign hold_1_s      = 1'b0;
`endif

  // Memory port and acks follow the current owner's live request lines
  always_comb begin
    mem_access_addr = {ADDR_W{1'b0}};
    mem_write_data  = {DATA_W{1'b0}};
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    ack_0           = 1'b0;
    ack_1           = 1'b0;
    case (state_q)
      OWN0: begin
        mem_access_addr = addr_0;
        mem_write_data  = wdata_0;
        mem_write_en    = req_0 & we_0;
        mem_read        = req_0 & ~we_0;
        ack_0           = req_0;
      end
      OWN1: begin
        mem_access_addr = addr_1;
        mem_write_data  = wdata_1;
        mem_write_en    = req_1 & we_1;
        mem_read        = req_1 & ~we_1;
        ack_1           = req_1;
      end
      default: begin
        mem_access_addr = {ADDR_W{1'b0}};
      end
    endcase
  end

  // A completed access makes its requester the most recent owner
  always_comb begin
    last_owner_d = last_owner_q;
    if (acc_0_s) begin
      last_owner_d = 1'b0;
    end else if (acc_1_s) begin
      last_owner_d = 1'b1;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Feeding the updated owner gives both the idle and the hand-over rules
  rr_pick2 u_pick (
    .req_0      (req_0),
    .req_1      (req_1),
    .last_owner (last_owner_d),
    .grant      (grant_s)
  );

  // Next owner: a locked access keeps the port, otherwise round-robin
  always_comb begin
    state_d = IDLE;
    if (hold_0_s) begin
      state_d = OWN0;
    end else if (hold_1_s) begin
      state_d = OWN1;
    end else begin
      state_d = grant_to_state(grant_s);
    end
  end

  // Read-return path: capture the memory word on the edge the read completes
  always_comb begin
    rvalid_0_d = acc_0_s & ~we_0;
    rvalid_1_d = acc_1_s & ~we_1;
    rdata_0_d  = rdata_0_q;
    rdata_1_d  = rdata_1_q;
    if (rvalid_0_d) begin
      rdata_0_d = mem_read_data;
    end else begin
      rdata_0_d = rdata_0_q;
    end
    if (rvalid_1_d) begin
      rdata_1_d = mem_read_data;
    end else begin
      rdata_1_d = rdata_1_q;
    end
  end

  // Arbiter FSM and its registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      rdata_0_q    <= {DATA_W{1'b0}};
      rdata_1_q    <= {DATA_W{1'b0}};
      rvalid_0_q   <= 1'b0;
      rvalid_1_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rdata_0_q    <= rdata_0_d;
      rdata_1_q    <= rdata_1_d;
      rvalid_0_q   <= rvalid_0_d;
      rvalid_1_q   <= rvalid_1_d;
    end
  end

  assign rdata_0  = rdata_0_q;
  assign rdata_1  = rdata_1_q;
  assign rvalid_0 = rvalid_0_q;
  assign rvalid_1 = rvalid_1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single Data_Memory port between requester 0 (core load/store stage) and requester 1 (debug/DMA loader). It owns the memory's address, write-data, write-enable and read strobes and grants one access per cycle with round-robin fairness. Read data is registered back to the winning requester.

## Interface
- ADDR_W, 16, address width passed to memory (memory decodes low bits only)
- DATA_W, 16, data word width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_0 / req_1  in  1  transaction request, held until ack
- we_0 / we_1  in  1  1 = write, 0 = read
- addr_0 / addr_1  in  ADDR_W  access address
- wdata_0 / wdata_1  in  DATA_W  write data
- lock_0 / lock_1  in  1  hold ownership after this access (used only with lock feature)
- ack_0 / ack_1  out  1  access performed at the coming rising edge
- rdata_0 / rdata_1  out  DATA_W  registered read data
- rvalid_0 / rvalid_1  out  1  one-cycle pulse: rdata_x updated
- mem_access_addr  out  ADDR_W  to memory
- mem_write_data  out  DATA_W  to memory
- mem_write_en  out  1  to memory
- mem_read  out  1  to memory
- mem_read_data  in  DATA_W  from memory (combinational read)

## Operation
- FSM states: IDLE, OWN0, OWN1. Register last_owner (1 bit).
- IDLE: memory outputs all 0, acks 0. Next: no req -> IDLE; one req -> OWN of that requester; both -> OWN of requester != last_owner.
- OWNx: memory outputs driven combinationally from requester x; mem_write_en = req_x & we_x; mem_read = req_x & ~we_x; ack_x = req_x; ack of other = 0.
- On edge in OWNx with req_x: access completes, last_owner <= x. Read: rdata_x <= mem_read_data, rvalid_x <= 1 next cycle. Write: memory updated, rdata_x unchanged, no rvalid.
- Next from OWNx: other req -> OWN other; else req_x -> OWNx (new transaction); else IDLE.
- req_x low in OWNx (protocol violation): no access, no ack, last_owner unchanged, next state per IDLE rules.
- req after ack is a new transaction; requester changes addr/we/wdata only on edges where ack seen.
- Addresses pass through unmodified; wrap/decoding is memory's concern.

## Timing
- Reset: state IDLE, last_owner = 1 (requester 0 wins first tie), all ack/rvalid 0, rdata_0/1 = 0, memory outputs 0.
- Latency from IDLE: req at cycle N -> ack at N+1 -> rvalid/rdata at N+2.
- Back-to-back: owner with continuous req and idle competitor gets one access per cycle.
- Both continuously requesting: strict alternation, one access per cycle, no bubble.
- Reset asserted mid-access: outputs drop immediately (async); write in that cycle does not occur; rvalid not issued.
- rvalid_x high exactly one cycle; rdata_x holds until next read by x.

## Configuration
- DMEM_ARB_LOCK_EN defined: in OWNx, access with lock_x = 1 forces next state OWNx regardless of other req (atomic read-modify-write); ownership released on first accepted access with lock_x = 0 or when req_x drops. Lock starvation bound is requester responsibility.
- Undefined: lock_0/lock_1 ports present but ignored; pure round-robin.

## Structure
- Shared package/header: ADDR_W, DATA_W defaults, state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2).
- Sub-module rr_pick2: combinational 2-way round-robin picker (req_0, req_1, last_owner -> grant vector).

## Test plan
- Reset, then req_0 read addr 3 (memory[3]=16'h00A5) -> ack_0 next cycle, rdata_0 = 16'h00A5 with rvalid_0 one cycle later.
- req_1 write 16'hBEEF to addr 5, then req_1 read addr 5 -> memory[5] = 16'hBEEF, rdata_1 = 16'hBEEF.
- req_0 and req_1 asserted together for 6 cycles from reset -> grants 0,1,0,1,0,1, no idle cycles.
- With DMEM_ARB_LOCK_EN: req_0 read addr 2 lock_0=1 then write addr 2 lock_0=0, req_1 waiting -> both req_0 accesses precede first ack_1.
- Assert rst during OWN1 write of 16'h1234 to addr 7 -> memory[7] unchanged, all outputs 0 immediately.
- req_0 dropped in OWN0 with req_1 high -> no ack_0, next cycle OWN1 with ack_1.
